// File: rtl/writeback_queue.sv
// Write-back sequencer: merges ALU and load results into an in-order FIFO,
// issues one register-file write per cycle and tracks pending destinations.
module writeback_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          aluValid,
    input  logic [ADDR_W-1:0]             aluDest,
    input  logic [DATA_W-1:0]             aluData,
    output logic                          aluReady,
    input  logic                          memValid,
    input  logic [ADDR_W-1:0]             memDest,
    input  logic [DATA_W-1:0]             memData,
    output logic                          memReady,
    output logic                          regWrite,
    output logic [ADDR_W-1:0]             writeRegister,
    output logic [DATA_W-1:0]             writeData,
    output logic [(1<<ADDR_W)-1:0]        pendingMask,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SB_W  = $clog2(DEPTH + 1) + 1;
    localparam int unsigned NREG  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    entry_t             fifo_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SB_W-1:0]    sb_q [NREG];
    logic [SB_W-1:0]    sb_d [NREG];
    logic [NREG-1:0]    pending_mask_q, pending_mask_d;
    logic               reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]  write_register_q, write_register_d;
    logic [DATA_W-1:0]  write_data_q, write_data_d;
    logic               overflow_q, overflow_d;

    logic [CNT_W-1:0]   free_c;
    logic               mem_ready_c, alu_ready_c;
    logic               mem_store_c, alu_store_c, pop_c;

    // Readiness depends on occupancy only; a same-cycle pop earns no credit.
    always_comb begin
        free_c      = CNT_W'(DEPTH) - count_q;
        mem_ready_c = (free_c != '0);
        alu_ready_c = (free_c >= CNT_W'(2)) || ((free_c != '0) && !memValid);
        mem_store_c = memValid && mem_ready_c && (memDest != '0);
        alu_store_c = aluValid && alu_ready_c && (aluDest != '0);
        pop_c       = (count_q != '0);
    end

    // Enqueue (load before ALU), drain head into output registers.
    always_comb begin
        fifo_d           = fifo_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        reg_write_d      = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (mem_store_c) begin
            fifo_d[wr_ptr_d] = '{dest: memDest, data: memData};
            wr_ptr_d         = wr_ptr_d + PTR_W'(1);
        end
        if (alu_store_c) begin
            fifo_d[wr_ptr_d] = '{dest: aluDest, data: aluData};
            wr_ptr_d         = wr_ptr_d + PTR_W'(1);
        end
        if (pop_c) begin
            reg_write_d      = 1'b1;
            write_register_d = fifo_q[rd_ptr_q].dest;
            write_data_d     = fifo_q[rd_ptr_q].data;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end
        count_d    = count_q + CNT_W'(mem_store_c) + CNT_W'(alu_store_c) - CNT_W'(pop_c);
        overflow_d = overflow_q || (aluValid && !alu_ready_c) || (memValid && !mem_ready_c);
    end

    // Scoreboard: count up on store, down when the issue cycle ends.
    always_comb begin
        pending_mask_d = '0;
        for (int i = 0; i < NREG; i++) begin
            sb_d[i] = sb_q[i];
            if (mem_store_c && (memDest == ADDR_W'(i)))
                sb_d[i] = sb_d[i] + SB_W'(1);
            if (alu_store_c && (aluDest == ADDR_W'(i)))
                sb_d[i] = sb_d[i] + SB_W'(1);
            if (reg_write_q && (write_register_q == ADDR_W'(i)))
                sb_d[i] = sb_d[i] - SB_W'(1);
            pending_mask_d[i] = (i != 0) && (sb_d[i] != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            for (int i = 0; i < NREG; i++)  sb_q[i]   <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            pending_mask_q   <= '0;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            overflow_q       <= 1'b0;
        end else begin
            fifo_q           <= fifo_d;
            sb_q             <= sb_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            pending_mask_q   <= pending_mask_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            overflow_q       <= overflow_d;
        end
    end

    assign aluReady      = alu_ready_c;
    assign memReady      = mem_ready_c;
    assign regWrite      = reg_write_q;
    assign writeRegister = write_register_q;
    assign writeData     = write_data_q;
    assign pendingMask   = pending_mask_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_writeback_queue.sv
// Directed testbench for writeback_queue with hand-computed expectations.
module tb_writeback_queue;
    logic       clock = 1'b0;
    logic       reset;
    logic       aluValid, memValid;
    logic [2:0] aluDest, memDest;
    logic [7:0] aluData, memData;
    logic       aluReady, memReady;
    logic       regWrite;
    logic [2:0] writeRegister;
    logic [7:0] writeData;
    logic [7:0] pendingMask;
    logic [2:0] count;
    logic       overflow;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    writeback_queue #(.DEPTH(4), .DATA_W(8), .ADDR_W(3)) dut (
        .clock(clock), .reset(reset),
        .aluValid(aluValid), .aluDest(aluDest), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memDest(memDest), .memData(memData), .memReady(memReady),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
        .pendingMask(pendingMask), .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic av, input logic [2:0] ad, input logic [7:0] adat,
                         input logic mv, input logic [2:0] md, input logic [7:0] mdat);
        aluValid = av; aluDest = ad; aluData = adat;
        memValid = mv; memDest = md; memData = mdat;
        #1;
    endtask

    task automatic idle();
        offer(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic expect_write(input string tag, input logic [2:0] r, input logic [7:0] d);
        check_eq({tag, ".we"},   32'(regWrite), 1);
        check_eq({tag, ".reg"},  32'(writeRegister), 32'(r));
        check_eq({tag, ".data"}, 32'(writeData), 32'(d));
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick(); tick();
        reset = 1'b0;
        check_eq("rst.we",    32'(regWrite), 0);
        check_eq("rst.count", 32'(count), 0);
        check_eq("rst.mask",  32'(pendingMask), 0);
        check_eq("rst.ovf",   32'(overflow), 0);
        check_eq("rst.wreg",  32'(writeRegister), 0);
        check_eq("rst.wdata", 32'(writeData), 0);
        check_eq("rst.aluRdy", 32'(aluReady), 1);
        check_eq("rst.memRdy", 32'(memReady), 1);
        tick();
        check_eq("idle.we",    32'(regWrite), 0);
        check_eq("idle.count", 32'(count), 0);

        // Single ALU write to r3
        offer(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
        tick(); idle();
        check_eq("alu1.count", 32'(count), 1);
        check_eq("alu1.mask",  32'(pendingMask), 32'h08);
        check_eq("alu1.we0",   32'(regWrite), 0);
        tick();
        expect_write("alu1.issue", 3'd3, 8'h5A);
        check_eq("alu1.mask2",  32'(pendingMask), 32'h08);
        check_eq("alu1.count2", 32'(count), 0);
        tick();
        check_eq("alu1.we_end",   32'(regWrite), 0);
        check_eq("alu1.mask_end", 32'(pendingMask), 0);
        check_eq("alu1.hold",     32'(writeData), 32'h5A);

        // Simultaneous offers: load retires first
        offer(1'b1, 3'd5, 8'h22, 1'b1, 3'd2, 8'h11);
        check_eq("sim.aluRdy", 32'(aluReady), 1);
        check_eq("sim.memRdy", 32'(memReady), 1);
        tick(); idle();
        check_eq("sim.count", 32'(count), 2);
        check_eq("sim.mask0", 32'(pendingMask), 32'h24);
        tick();
        expect_write("sim.w0", 3'd2, 8'h11);
        check_eq("sim.mask1", 32'(pendingMask), 32'h24);
        tick();
        expect_write("sim.w1", 3'd5, 8'h22);
        check_eq("sim.mask2", 32'(pendingMask), 32'h20);
        tick();
        check_eq("sim.we_end", 32'(regWrite), 0);
        check_eq("sim.mask3",  32'(pendingMask), 0);

        // Fill while draining; ALU offer dropped when only one slot is free
        offer(1'b1, 3'd2, 8'h42, 1'b1, 3'd1, 8'h41);
        tick();
        check_eq("fill.count1", 32'(count), 2);
        offer(1'b1, 3'd4, 8'h44, 1'b1, 3'd3, 8'h43);
        check_eq("fill.aluRdy2", 32'(aluReady), 1);
        tick();
        check_eq("fill.count2", 32'(count), 3);
        expect_write("fill.w1", 3'd1, 8'h41);
        check_eq("fill.ovf0", 32'(overflow), 0);
        offer(1'b1, 3'd6, 8'h46, 1'b1, 3'd5, 8'h45);
        check_eq("fill.memRdy3", 32'(memReady), 1);
        check_eq("fill.aluRdy3", 32'(aluReady), 0);
        tick(); idle();
        check_eq("fill.aluRdy_solo", 32'(aluReady), 1);
        check_eq("fill.ovf1",   32'(overflow), 1);
        check_eq("fill.count3", 32'(count), 3);
        check_eq("fill.mask3",  32'(pendingMask), 32'h3C);
        expect_write("fill.w2", 3'd2, 8'h42);
        tick();
        expect_write("fill.w3", 3'd3, 8'h43);
        tick();
        expect_write("fill.w4", 3'd4, 8'h44);
        tick();
        expect_write("fill.w5", 3'd5, 8'h45);
        check_eq("fill.count_end", 32'(count), 0);
        tick();
        check_eq("fill.we_end",  32'(regWrite), 0);
        check_eq("fill.mask_end", 32'(pendingMask), 0);
        check_eq("fill.ovf_sticky", 32'(overflow), 1);

        // r0 writes are consumed silently
        offer(1'b1, 3'd0, 8'h77, 1'b0, 3'd0, 8'h00);
        check_eq("r0.aluRdy", 32'(aluReady), 1);
        tick(); idle();
        check_eq("r0.count", 32'(count), 0);
        check_eq("r0.mask",  32'(pendingMask), 0);
        tick();
        check_eq("r0.we", 32'(regWrite), 0);

        // Back-to-back writes to r6
        offer(1'b1, 3'd6, 8'hAA, 1'b0, 3'd0, 8'h00);
        tick();
        check_eq("r6.mask0", 32'(pendingMask), 32'h40);
        offer(1'b1, 3'd6, 8'hBB, 1'b0, 3'd0, 8'h00);
        tick(); idle();
        expect_write("r6.w0", 3'd6, 8'hAA);
        check_eq("r6.mask1", 32'(pendingMask), 32'h40);
        check_eq("r6.count", 32'(count), 1);
        tick();
        expect_write("r6.w1", 3'd6, 8'hBB);
        check_eq("r6.mask2", 32'(pendingMask), 32'h40);
        tick();
        check_eq("r6.we_end", 32'(regWrite), 0);
        check_eq("r6.mask3",  32'(pendingMask), 0);

        // Reset while a write is being issued
        offer(1'b1, 3'd2, 8'h20, 1'b1, 3'd1, 8'h10);
        tick();
        offer(1'b1, 3'd3, 8'h30, 1'b0, 3'd0, 8'h00);
        tick(); idle();
        expect_write("mid.w0", 3'd1, 8'h10);
        check_eq("mid.count", 32'(count), 2);
        check_eq("mid.ovf_pre", 32'(overflow), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid.we",    32'(regWrite), 0);
        check_eq("mid.count0", 32'(count), 0);
        check_eq("mid.mask",  32'(pendingMask), 0);
        check_eq("mid.ovf",   32'(overflow), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mid.no_write", 32'(regWrite), 0);
            check_eq("mid.mask_idle", 32'(pendingMask), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
